seg_display_ctrl: RTL and testbench

- Drives the two 4-digit seven-segment banks used for ecall output.
- Captures a 32-bit value on a load pulse and renders it as 8 hex digits or a signed decimal with leading-zero blanking.
- Decimal conversion is a sequential double-dabble engine.
- Continuously time-multiplexes both banks; sits between the ecall I/O handler and the board pins.

---
 rtl/seg_display_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_seg_display_ctrl.sv | 138 +++++++++++++
 2 files changed

// File: rtl/seg_display_ctrl.sv
// seg_display_ctrl: drives the two 4-digit seven-segment banks used for ecall
// output. A load pulse captures a 32-bit value and shows it either as eight
// hex digits or as a signed decimal with leading-zero blanking. Decimal
// conversion runs on a 32-cycle sequential double-dabble engine.
//
// Ports:
//   clk      system clock
//   rst      asynchronous reset, active low
//   load     single-cycle capture request (ignored while busy)
//   data     value to display
//   mode     0 = hex, 1 = signed decimal
//   busy     decimal conversion in progress
//   seg      per-bank segment pattern, bit7..bit0 = a,b,c,d,e,f,g,dp
//   seg_sel  per-bank one-hot digit select; seg_sel[b][i] = digit 4*b+i
module seg_display_ctrl #(
  parameter int SCAN_DIV        = 100000,
  parameter bit SEG_ACTIVE_HIGH = 1'b1,
  parameter bit SEL_ACTIVE_HIGH = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [31:0]     data,
  input  logic            mode,
  output logic            busy,
  output logic [1:0][7:0] seg,
  output logic [1:0][3:0] seg_sel
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_CONV = 1'b1;

  // Digit codes: 0..15 hex value, plus two symbols.
  localparam logic [4:0] C_DASH  = 5'd16;
  localparam logic [4:0] C_BLANK = 5'd17;

  function automatic logic [7:0] glyph(input logic [4:0] c);
    case (c)
      5'd0:    glyph = 8'hFC;
      5'd1:    glyph = 8'h60;
      5'd2:    glyph = 8'hDA;
      5'd3:    glyph = 8'hF2;
      5'd4:    glyph = 8'h66;
      5'd5:    glyph = 8'hB6;
      5'd6:    glyph = 8'hBE;
      5'd7:    glyph = 8'hE0;
      5'd8:    glyph = 8'hFE;
      5'd9:    glyph = 8'hF6;
      5'd10:   glyph = 8'hEE;
      5'd11:   glyph = 8'h3E;
      5'd12:   glyph = 8'h9C;
      5'd13:   glyph = 8'h7A;
      5'd14:   glyph = 8'h9E;
      5'd15:   glyph = 8'h8E;
      5'd16:   glyph = 8'h02;
      default: glyph = 8'h00;
    endcase
  endfunction

  logic [0:0]       state_q, state_d;
  logic [31:0]      mag_q, mag_d;
  logic [39:0]      bcd_q, bcd_d, bcd_adj, bcd_nxt;
  logic             sign_q, sign_d;
  logic [4:0]       bit_q, bit_d;
  logic [7:0][4:0]  dig_q, dig_d, fmt;
  logic             lead, oor;

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic             scan_tc;
  logic [1:0][7:0]  seg_q, seg_d;
  logic [1:0][3:0]  sel_q, sel_d;

  // One double-dabble step: add 3 to every nibble >= 5, then shift in the
  // next magnitude bit. bcd_nxt on the last step is the final BCD result.
  always_comb begin
    bcd_adj = bcd_q;
    for (int n = 0; n < 10; n++)
      if (bcd_q[4*n +: 4] >= 4'd5) bcd_adj[4*n +: 4] = bcd_q[4*n +: 4] + 4'd3;
    bcd_nxt = {bcd_adj[38:0], mag_q[31]};
  end

  // Decimal formatting of the final BCD value into digit codes.
  always_comb begin
    fmt  = {8{C_BLANK}};
    lead = 1'b1;
    for (int k = 7; k >= 0; k--) begin
      if (lead && k != 0 && bcd_nxt[4*k +: 4] == 4'd0) begin
        fmt[k] = C_BLANK;
      end else begin
        lead   = 1'b0;
        fmt[k] = {1'b0, bcd_nxt[4*k +: 4]};
      end
    end
    // Walk downward so the freshly placed '-' is not seen as a digit below.
    if (sign_q)
      for (int k = 7; k >= 1; k--)
        if (fmt[k] == C_BLANK && fmt[k-1] != C_BLANK) fmt[k] = C_DASH;
    // Negative numbers leave one position for the sign: 7 digits max.
    oor = sign_q ? (bcd_nxt[39:28] != 12'd0) : (bcd_nxt[39:32] != 8'd0);
    if (oor) begin
      fmt    = {8{C_BLANK}};
      fmt[0] = 5'd14;
    end
  end

  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    bcd_d   = bcd_q;
    sign_d  = sign_q;
    bit_d   = bit_q;
    dig_d   = dig_q;
    case (state_q)
      S_IDLE: begin
        if (load) begin
          if (mode) begin
            state_d = S_CONV;
            sign_d  = data[31];
            mag_d   = data[31] ? (~data + 32'd1) : data;
            bcd_d   = '0;
            bit_d   = '0;
          end else begin
            for (int k = 0; k < 8; k++) dig_d[k] = {1'b0, data[4*k +: 4]};
          end
        end
      end
      default: begin
        bcd_d = bcd_nxt;
        mag_d = {mag_q[30:0], 1'b0};
        bit_d = bit_q + 5'd1;
        if (bit_q == 5'd31) begin
          state_d = S_IDLE;
          dig_d   = fmt;
        end
      end
    endcase
  end

  // Scan: both banks share the index; seg/sel reload together on terminal count.
  always_comb begin
    scan_tc = (cnt_q == CW'(SCAN_DIV - 1));
    cnt_d   = scan_tc ? '0 : cnt_q + CW'(1);
    idx_d   = idx_q + {1'b0, scan_tc};
    seg_d   = seg_q;
    sel_d   = sel_q;
    if (scan_tc) begin
      for (int b = 0; b < 2; b++) begin
        seg_d[b] = glyph(dig_q[{b[0], idx_d}]);
        sel_d[b] = 4'b0001 << idx_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      mag_q   <= '0;
      bcd_q   <= '0;
      sign_q  <= 1'b0;
      bit_q   <= '0;
      dig_q   <= {8{C_BLANK}};
      cnt_q   <= '0;
      idx_q   <= '0;
      seg_q   <= '0;
      sel_q   <= {2{4'b0001}};
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      bcd_q   <= bcd_d;
      sign_q  <= sign_d;
      bit_q   <= bit_d;
      dig_q   <= dig_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      sel_q   <= sel_d;
    end
  end

  assign busy    = (state_q == S_CONV);
  assign seg     = seg_q ^ {16{!SEG_ACTIVE_HIGH}};
  assign seg_sel = sel_q ^ {8{!SEL_ACTIVE_HIGH}};

endmodule

// File: tb/tb_seg_display_ctrl.sv
module tb_seg_display_ctrl;

  logic            clk = 1'b0;
  logic            rst;
  logic            load;
  logic [31:0]     data;
  logic            mode;
  logic            busy;
  logic [1:0][7:0] seg;
  logic [1:0][3:0] seg_sel;

  int total = 0;
  int passed = 0;

  seg_display_ctrl #(.SCAN_DIV(4)) dut (
    .clk(clk), .rst(rst), .load(load), .data(data), .mode(mode),
    .busy(busy), .seg(seg), .seg_sel(seg_sel)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        m;
    logic [63:0] e;  // digit k glyph at [8k+:8]
  } vec_t;

  vec_t        vecs[9];
  logic [63:0] sb_q[$];
  logic [63:0] prev_exp;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) $display("FAIL %s: got %h want %h", name, got, want);
    else passed++;
  endtask

  // Record which glyph each digit position shows over n negedge samples.
  task automatic capture(input int n, output logic [63:0] g);
    g = '0;
    repeat (n) begin
      @(negedge clk);
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < 4; i++)
          if (seg_sel[b][i]) g[(4*b+i)*8 +: 8] = seg[b];
    end
  endtask

  task automatic do_load(input logic [31:0] d, input logic m, input logic [63:0] e,
                         input int poke_at);
    logic [63:0] held, g, exp;
    int n;
    @(negedge clk);
    data = d; mode = m; load = 1'b1;
    sb_q.push_back(e);
    @(negedge clk);
    load = 1'b0;
    if (m) begin
      n = 0;
      held = '0;
      while (busy && n < 100) begin
        for (int b = 0; b < 2; b++)
          for (int i = 0; i < 4; i++)
            if (seg_sel[b][i]) held[(4*b+i)*8 +: 8] = seg[b];
        n++;
        if (n == poke_at) begin data = 32'd1; mode = 1'b0; end
        load = (n == poke_at);
        @(negedge clk);
      end
      load = 1'b0;
      chk("busy_len", 64'(n), 64'd32);
      chk("hold_old", held, prev_exp);
    end else begin
      chk("hex_busy", {63'd0, busy}, 64'd0);
    end
    repeat (16) @(negedge clk);
    capture(16, g);
    exp = sb_q.pop_front();
    chk("display", g, exp);
    prev_exp = exp;
  endtask

  initial begin
    logic [63:0] g;
    vecs[0] = '{32'h1234ABCD, 1'b0, 64'h60DAF266_EE3E9C7A};
    vecs[1] = '{32'hFFFFFFD6, 1'b1, 64'h00000000_000266DA};
    vecs[2] = '{32'd0,        1'b1, 64'h00000000_000000FC};
    vecs[3] = '{32'd99999999, 1'b1, 64'hF6F6F6F6_F6F6F6F6};
    vecs[4] = '{32'd100000000,1'b1, 64'h00000000_0000009E};
    vecs[5] = '{32'hFF676980, 1'b1, 64'h00000000_0000009E};
    vecs[6] = '{32'h80000000, 1'b1, 64'h00000000_0000009E};
    vecs[7] = '{32'hFF676981, 1'b1, 64'h02F6F6F6_F6F6F6F6};
    vecs[8] = '{32'h0000BEEF, 1'b0, 64'hFCFCFCFC_3E9E9E8E};

    rst = 1'b0; load = 1'b0; data = '0; mode = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_state", {47'd0, busy, seg, seg_sel}, {47'd0, 1'b0, 16'h0000, 8'h11});

    // Scan walk after reset release.
    rst = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 3) chk("pre_adv", {48'd0, seg, seg_sel}, {48'd0, 16'h0000, 8'h11});
      if (k % 4 == 0) begin
        logic [3:0] oh;
        oh = 4'b0001 << ((k / 4) % 4);
        chk("sel_walk", {56'd0, seg_sel}, {56'd0, oh, oh});
      end
    end

    prev_exp = '0;
    for (int v = 0; v < 9; v++) do_load(vecs[v].d, vecs[v].m, vecs[v].e, -1);

    // Hex load issued while busy must be dropped.
    do_load(32'd12345, 1'b1, 64'h00000060_DAF266B6, 10);

    // Reset in the middle of a conversion.
    @(negedge clk);
    data = 32'd42; mode = 1'b1; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (16) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst", {47'd0, busy, seg, seg_sel}, {47'd0, 1'b0, 16'h0000, 8'h11});
    @(negedge clk);
    rst = 1'b1;
    repeat (16) @(negedge clk);
    capture(16, g);
    chk("blank_after_rst", g, 64'd0);
    prev_exp = '0;
    do_load(32'h0, 1'b0, 64'hFCFCFCFC_FCFCFCFC, -1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
